// File: rtl/board_renderer.sv
// 4x4 tile-board renderer: two-stage pixel pipeline turning timing-generator
// coordinates into a {R4,G4,B4} colour, with a frame-synchronous board swap.
module board_renderer #(
    parameter int BX   = 120,
    parameter int BY   = 40,
    parameter int TILE = 96,
    parameter int GAP  = 4
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        valid,
    input  logic [10:0] h_cnt,
    input  logic [10:0] v_cnt,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        upd_valid,
    input  logic [63:0] upd_board,
    output logic        upd_ready,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int          P    = GAP + TILE;
    localparam logic [10:0] H_LO = 11'(BX);
    localparam logic [10:0] H_HI = 11'(BX + 4 * P);
    localparam logic [10:0] V_LO = 11'(BY);
    localparam logic [10:0] V_HI = 11'(BY + 4 * P);
    localparam logic [10:0] P_M1 = 11'(P - 1);
    localparam logic [10:0] G_L  = 11'(GAP);

    // offset counters hold the position of the last pixel/line seen
    logic [10:0] coff_q, coff_d, roff_q, roff_d;
    logic [1:0]  col_q, col_d, row_q, row_d;

    // stage 1
    logic        vld1_q, vld1_d, in1_q, in1_d, gap1_q, gap1_d;
    logic [1:0]  row1_q, row1_d, col1_q, col1_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;

    // stage 2
    logic [11:0] rgb_q, rgb_d;
    logic        hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d;

    // board storage
    logic        pend_q, pend_d;
    logic [63:0] pbrd_q, pbrd_d, disp_q, disp_d;

    logic        fs;
    logic [3:0]  tile_e;

    assign fs     = valid && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    assign tile_e = disp_q[{row1_q, col1_q, 2'b00} +: 4];

    always_comb begin
        coff_d = coff_q;
        col_d  = col_q;
        roff_d = roff_q;
        row_d  = row_q;
        if (valid) begin
            if (h_cnt == H_LO) begin
                coff_d = '0;
                col_d  = '0;
            end else if (coff_q == P_M1) begin
                coff_d = '0;
                col_d  = col_q + 2'd1;
            end else begin
                coff_d = coff_q + 11'd1;
            end
            if (h_cnt == 11'd0) begin
                if (v_cnt == V_LO) begin
                    roff_d = '0;
                    row_d  = '0;
                end else if (roff_q == P_M1) begin
                    roff_d = '0;
                    row_d  = row_q + 2'd1;
                end else begin
                    roff_d = roff_q + 11'd1;
                end
            end
        end
    end

    // the _d counter values are the offsets of the pixel currently presented
    always_comb begin
        vld1_d = valid;
        in1_d  = (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);
        gap1_d = (coff_d < G_L) || (roff_d < G_L);
        row1_d = row_d;
        col1_d = col_d;
        hs1_d  = hsync_in;
        vs1_d  = vsync_in;
        fs1_d  = fs;
    end

    always_comb begin
        rgb_d = 12'h000;
        if (!vld1_q)      rgb_d = 12'h000;
        else if (!in1_q)  rgb_d = 12'hFEE;
        else if (gap1_q)  rgb_d = 12'hBAA;
        else begin
            case (tile_e)
                4'd0:    rgb_d = 12'hCBA;
                4'd1:    rgb_d = 12'hEED;
                4'd2:    rgb_d = 12'hEEC;
                4'd3:    rgb_d = 12'hF97;
                4'd4:    rgb_d = 12'hF86;
                4'd5:    rgb_d = 12'hF75;
                4'd6:    rgb_d = 12'hF53;
                4'd7:    rgb_d = 12'hEC7;
                4'd8:    rgb_d = 12'hEC6;
                4'd9:    rgb_d = 12'hEC5;
                4'd10:   rgb_d = 12'hEC3;
                4'd11:   rgb_d = 12'hEC2;
                default: rgb_d = 12'h333;
            endcase
        end
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        fs2_d = fs1_q;
    end

    // a transfer can only happen with pending clear, so it never collides with a swap
    always_comb begin
        pend_d = pend_q;
        pbrd_d = pbrd_q;
        disp_d = disp_q;
        if (fs && pend_q) begin
            disp_d = pbrd_q;
            pend_d = 1'b0;
        end
        if (upd_valid && !pend_q) begin
            pbrd_d = upd_board;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            coff_q <= '0;
            col_q  <= '0;
            roff_q <= '0;
            row_q  <= '0;
            vld1_q <= 1'b0;
            in1_q  <= 1'b0;
            gap1_q <= 1'b0;
            row1_q <= '0;
            col1_q <= '0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            fs1_q  <= 1'b0;
            rgb_q  <= '0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            fs2_q  <= 1'b0;
            pend_q <= 1'b0;
            pbrd_q <= '0;
            disp_q <= '0;
        end else begin
            coff_q <= coff_d;
            col_q  <= col_d;
            roff_q <= roff_d;
            row_q  <= row_d;
            vld1_q <= vld1_d;
            in1_q  <= in1_d;
            gap1_q <= gap1_d;
            row1_q <= row1_d;
            col1_q <= col1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            fs1_q  <= fs1_d;
            rgb_q  <= rgb_d;
            hs2_q  <= hs2_d;
            vs2_q  <= vs2_d;
            fs2_q  <= fs2_d;
            pend_q <= pend_d;
            pbrd_q <= pbrd_d;
            disp_q <= disp_d;
        end
    end

    assign upd_ready   = !pend_q;
    assign rgb         = rgb_q;
    assign hsync       = hs2_q;
    assign vsync       = vs2_q;
    assign frame_start = fs2_q;

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter BX, 120, board left edge (pixel column).
REQ-002 SHALL have parameter BY, 40, board top edge (line).
REQ-003 SHALL have parameter TILE, 96, tile side in pixels.
REQ-004 SHALL have parameter GAP, 4, gap width before each tile; pitch P = GAP+TILE = 100; board spans 4*P pixels per axis.
REQ-005 SHALL have port pclk  input  1  pixel clock; sole clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port valid  input  1  active-video flag from the timing generator.
REQ-008 SHALL have port h_cnt  input  11  pixel column; 0 outside active video.
REQ-009 SHALL have port v_cnt  input  11  line; 0 outside active video.
REQ-010 SHALL have port hsync_in / vsync_in  input  1 each  sync from the timing generator.
REQ-011 SHALL have port upd_valid  input  1  new board offered.
REQ-012 SHALL have port upd_board  input  64  16 tiles x 4-bit exponent; tile (r,c) at bits [4*(4r+c)+3 : 4*(4r+c)].
REQ-013 SHALL have port upd_ready  output  1  block can accept a board.
REQ-014 SHALL have port rgb  output  12  {R4,G4,B4} pixel colour.
REQ-015 SHALL have port hsync / vsync  output  1 each  sync delayed to align with rgb.
REQ-016 SHALL have port frame_start  output  1  one-cycle pulse when the display board is swapped.

Function
REQ-017 Pipeline SHALL be exactly 2 pclk cycles: rgb, hsync, vsync at cycle n+2 correspond to valid/h_cnt/v_cnt/hsync_in/vsync_in at cycle n.
REQ-018 Stage 1 SHALL register inside-board flag, tile row/col (0..3) and in-gap flag from running per-line/per-frame offset counters; no divider or modulo operators.
REQ-019 Column counter SHALL load 0 at h_cnt==BX, step each pixel and wrap at P-1, incrementing col 0->3; line counter likewise at v_cnt==BY on the first pixel of each line (valid && h_cnt==0).
REQ-020 Pixel inside board when BX<=h_cnt<BX+4P and BY<=v_cnt<BY+4P; in gap when column offset<GAP or row offset<GAP.
REQ-021 Stage 2 colour: valid==0 -> 12'h000; outside board -> 12'hFEE; gap -> 12'hBAA; tile exponent e: 0->CBA, 1->EED, 2->EEC, 3->F97, 4->F86, 5->F75, 6->F53, 7->EC7, 8->EC6, 9->EC5, 10->EC3, 11->EC2, 12..15->333.
REQ-022 Handshake: transfer when upd_valid && upd_ready; upd_board captured into pending register, pending flag set, upd_ready low from next cycle.
REQ-023 Frame boundary fs = valid && h_cnt==0 && v_cnt==0 (input side).
REQ-024 On fs with pending flag set: display <= pending, pending flag cleared, upd_ready high next cycle, frame_start pulses at the same cycle as that pixel's rgb (fs delayed 2).
REQ-025 On fs with no pending board: display unchanged, frame_start still pulses.
REQ-026 Transfer and fs in same cycle: display takes the previously pending value only if pending was already set (impossible since ready low), so new board is held and applied at the next fs.
REQ-027 upd_board ignored while upd_ready low; display never changes mid-frame.

Reset
REQ-028 While reset low: rgb=0, hsync=vsync=1, frame_start=0, upd_ready=1, pending flag 0, display and pending boards all-zero, counters 0.
REQ-029 Reset assertion SHALL take effect asynchronously; release SHALL be sampled on pclk, outputs valid from first following frame.

Verification
REQ-030 Reset, full 640x480 frame, display all-zero -> pixel (0,0) = FEE; (124,44) = CBA; (121,41) = BAA; valid low -> 000.
REQ-031 Offer board with tile(0,0)=1, tile(3,3)=11 mid-frame -> upd_ready drops next cycle, colours unchanged until next fs; after fs (124,44)=EED, (424,344)=EC2, upd_ready high.
REQ-032 Exponents 12 and 15 in tile(1,2) -> (344,144) = 333.
REQ-033 upd_valid held high across two frames with changing data -> exactly one board accepted per frame; each shown only from the frame after capture.
REQ-034 Compare rgb/hsync/vsync against h_cnt/hsync_in delayed 2 cycles over a whole frame -> zero misalignment; frame_start one pulse per frame.
REQ-035 Assert reset mid-line with pending board -> outputs reset values immediately; pending discarded, upd_ready=1 after release.
